// File: rtl/ritmo_ctrl.sv
// Rhythm-game controller: the player presses a key inside a window at the start of each beat.
// Hits and misses are scored and flashed on green/red LEDs, and the game ends after ROUNDS beats or MAXMISS misses.
module ritmo_ctrl #(
  parameter int PERIOD  = 25_000_000,
  parameter int WIN     = 2_500_000,
  parameter int HOLD    = 5_000_000,
  parameter int ROUNDS  = 16,
  parameter int MAXMISS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       start,
  output logic       green,
  output logic       red,
  output logic       beat,
  output logic [1:0] beat_idx,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic       busy,
  output logic       done,
  output logic       over
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_beat_cnt;
  logic [7:0]      r_score;
  logic [2:0]      r_misses;
  logic [HW-1:0]   r_hold;
  logic            r_judged;
  logic            r_green;
  logic            r_red;
  logic            r_over;
  logic            r_key_q;
  logic            r_start_q;

  logic            w_key_edge;
  logic            w_start_edge;
  logic            w_play;
  logic            w_in_win;
  logic            w_wrap;
  logic            w_hit;
  logic            w_miss;
  logic [2:0]      w_misses_nx;
  logic            w_maxed;
  logic            w_last;

  assign w_key_edge   = key & ~r_key_q;
  assign w_start_edge = start & ~r_start_q;
  assign w_play       = (r_state == PLAY);
  assign w_in_win     = (r_cnt < CW'(WIN));
  assign w_wrap       = (r_cnt == CW'(PERIOD - 1));

  // An early or repeated press is a miss but does not close the beat; only a hit or an expiry does.
  assign w_hit       = w_play & w_key_edge & w_in_win & ~r_judged;
  assign w_miss      = w_play & ((w_key_edge & ~w_hit)
                     | (~w_key_edge & (r_cnt == CW'(WIN)) & ~r_judged));
  assign w_misses_nx = r_misses + 3'd1;
  assign w_maxed     = w_miss & (w_misses_nx == 3'(MAXMISS));
  assign w_last      = w_play & w_wrap & ((r_beat_cnt + 8'd1) == 8'(ROUNDS));

  assign green    = r_green;
  assign red      = r_red;
  assign beat     = w_play & w_in_win;
  assign beat_idx = r_beat_cnt[1:0];
  assign score    = r_score;
  assign misses   = r_misses;
  assign busy     = w_play;
  assign done     = (r_state == DONE);
  assign over     = r_over;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_beat_cnt <= '0;
      r_score    <= '0;
      r_misses   <= '0;
      r_hold     <= '0;
      r_judged   <= 1'b0;
      r_green    <= 1'b0;
      r_red      <= 1'b0;
      r_over     <= 1'b0;
      // Edge registers come out of reset high so inputs held through reset produce no edge.
      r_key_q    <= 1'b1;
      r_start_q  <= 1'b1;
    end else begin
      r_key_q   <= key;
      r_start_q <= start;

      if (r_hold != '0) begin
        r_hold <= r_hold - HW'(1);
        if (r_hold == HW'(1)) begin
          r_green <= 1'b0;
          r_red   <= 1'b0;
        end
      end

      // NOTE: non-blocking assignments -- the last one in program order wins, so later
      // blocks below deliberately override the hold-timer expiry and the judgement flag.
      case (r_state)
        IDLE, DONE: begin
          if (w_start_edge) begin
            r_state    <= PLAY;
            r_cnt      <= '0;
            r_beat_cnt <= '0;
            r_score    <= '0;
            r_misses   <= '0;
            r_hold     <= '0;
            r_judged   <= 1'b0;
            r_green    <= 1'b0;
            r_red      <= 1'b0;
            r_over     <= 1'b0;
          end
        end

        PLAY: begin
          if (w_hit) begin
            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            r_judged <= 1'b1;
            r_green  <= 1'b1;
            r_red    <= 1'b0;
            r_hold   <= HW'(HOLD);
          end else if (w_miss) begin
            r_misses <= w_misses_nx;
            r_judged <= 1'b1;
            r_green  <= 1'b0;
            r_red    <= 1'b1;
            r_hold   <= HW'(HOLD);
          end

          // A new beat always starts unjudged, even if the old one was judged this cycle.
          if (w_wrap) begin
            r_cnt      <= '0;
            r_beat_cnt <= r_beat_cnt + 8'd1;
            r_judged   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end

          if (w_maxed) begin
            r_state <= DONE;
            r_over  <= 1'b1;
          end else if (w_last) begin
            r_state <= DONE;
            r_over  <= 1'b0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ritmo_ctrl.sv
// Directed bench for ritmo_ctrl with small parameters: a per-cycle vector table plus
// hand-written sequences for expiry, full game, held key through reset and async abort.
module tb_ritmo_ctrl;

  localparam int PERIOD  = 20;
  localparam int WIN     = 5;
  localparam int HOLD    = 3;
  localparam int ROUNDS  = 4;
  localparam int MAXMISS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key = 1'b0;
  logic       start = 1'b0;
  logic       green, red, beat, busy, done, over;
  logic [1:0] beat_idx;
  logic [7:0] score;
  logic [2:0] misses;

  int checks   = 0;
  int failures = 0;

  ritmo_ctrl #(
    .PERIOD(PERIOD), .WIN(WIN), .HOLD(HOLD), .ROUNDS(ROUNDS), .MAXMISS(MAXMISS)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .start(start),
    .green(green), .red(red), .beat(beat), .beat_idx(beat_idx),
    .score(score), .misses(misses), .busy(busy), .done(done), .over(over)
  );

  always #5 clk = ~clk;

  // Packed view: {green, red, beat, busy, done, over, beat_idx, misses, score}
  logic [18:0] obs;
  assign obs = {green, red, beat, busy, done, over, beat_idx, misses, score};

  typedef struct {
    logic       start;
    logic       key;
    int         n;
    logic       g, r, bt, bsy, dn, ov;
    logic [1:0] idx;
    logic [2:0] m;
    logic [7:0] s;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // From cnt == 0 of a beat: press at cnt == 2, then run to cnt == 0 of the next beat.
  task automatic hit_beat();
    tick(2);
    key = 1'b1;
    tick(1);
    key = 1'b0;
    tick(17);
  endtask

  function automatic vec_t mk(input logic st, input logic k, input int n,
                              input logic g, input logic r, input logic bt,
                              input logic [1:0] idx, input logic [2:0] m,
                              input logic [7:0] s);
    vec_t v;
    v.start = st; v.key = k; v.n = n;
    v.g = g; v.r = r; v.bt = bt; v.bsy = 1'b1; v.dn = 1'b0; v.ov = 1'b0;
    v.idx = idx; v.m = m; v.s = s;
    return v;
  endfunction

  initial begin
    //           st k  n  g r bt idx m s
    vecs[0]  = mk(1, 0, 1, 0,0,1, 0, 0, 0);   // cnt 0, game running
    vecs[1]  = mk(1, 0, 1, 0,0,1, 0, 0, 0);   // start held: no restart
    vecs[2]  = mk(0, 0, 1, 0,0,1, 0, 0, 0);   // cnt 2
    vecs[3]  = mk(0, 1, 1, 1,0,1, 0, 0, 1);   // key edge at cnt 2: hit
    vecs[4]  = mk(0, 1, 1, 1,0,1, 0, 0, 1);   // key held: no edge
    vecs[5]  = mk(0, 0, 1, 1,0,0, 0, 0, 1);   // cnt 5: window closed, judged
    vecs[6]  = mk(0, 0, 1, 0,0,0, 0, 0, 1);   // green held 3 cycles, now off
    vecs[7]  = mk(0, 0, 13, 0,0,0, 0, 0, 1);  // cnt 19
    vecs[8]  = mk(0, 0, 1, 0,0,1, 1, 0, 1);   // wrap to beat 1
    vecs[9]  = mk(0, 0, 1, 0,0,1, 1, 0, 1);   // cnt 1
    vecs[10] = mk(0, 1, 1, 1,0,1, 1, 0, 2);   // hit at cnt 1
    vecs[11] = mk(0, 0, 1, 1,0,1, 1, 0, 2);   // cnt 3
    vecs[12] = mk(0, 1, 1, 0,1,1, 1, 1, 2);   // double press at cnt 3: red
    vecs[13] = mk(0, 0, 1, 0,1,0, 1, 1, 2);   // cnt 5: no expiry, already judged
    vecs[14] = mk(0, 0, 1, 0,1,0, 1, 1, 2);
    vecs[15] = mk(0, 0, 1, 0,0,0, 1, 1, 2);   // red hold complete

    do_reset();

    // Hit, hold timing, double press
    foreach (vecs[i]) begin
      logic [18:0] exp;
      start = vecs[i].start;
      key   = vecs[i].key;
      tick(vecs[i].n);
      exp = {vecs[i].g, vecs[i].r, vecs[i].bt, vecs[i].bsy, vecs[i].dn, vecs[i].ov,
             vecs[i].idx, vecs[i].m, vecs[i].s};
      check($sformatf("vec%0d", i), 32'(obs), 32'(exp));
    end
    start = 1'b0;
    key   = 1'b0;

    // Window expiry on beats 0 and 1 ends the game with over
    do_reset();
    start_game();
    tick(6);
    check("expiry0_red_misses", {30'd0, red, green}, 32'b10);
    check("expiry0_misses", 32'(misses), 32'd1);
    tick(19);
    check("expiry1_before", {28'd0, busy, done, beat_idx}, 32'b1001);
    tick(1);
    check("maxmiss_state", {28'd0, busy, done, over, red}, 32'b0111);
    check("maxmiss_counts", {21'd0, misses, score}, {21'd0, 3'd2, 8'd0});
    tick(2);
    check("maxmiss_red_hold", 32'(red), 32'd1);
    tick(1);
    check("maxmiss_red_off", 32'(red), 32'd0);
    key = 1'b1;
    tick(1);
    key = 1'b0;
    tick(1);
    check("done_key_ignored", {21'd0, misses, score}, {21'd0, 3'd2, 8'd0});

    // Full game of four hits, restart from DONE, start ignored mid-game
    start_game();
    check("restart_from_done", {28'd0, busy, done, over, 1'b0}, 32'b1000);
    for (int b = 0; b < ROUNDS; b++) begin
      check($sformatf("beat_idx_b%0d", b), 32'(beat_idx), 32'(b));
      if (b == 1) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        key = 1'b1;
        tick(1);
        key = 1'b0;
        tick(17);
      end else begin
        hit_beat();
      end
    end
    check("full_game_state", {28'd0, busy, done, over, 1'b0}, 32'b0100);
    check("full_game_counts", {21'd0, misses, score}, {21'd0, 3'd0, 8'd4});

    // Key held through reset release: no judgement until a fresh rise
    key = 1'b1;
    do_reset();
    start_game();
    tick(2);
    check("held_key_no_judge", {19'd0, green, red, misses, score}, 32'd0);
    key = 1'b0;
    tick(1);
    key = 1'b1;
    tick(1);
    check("held_key_fresh_hit", {19'd0, green, red, misses, score}, {19'd0, 1'b1, 1'b0, 3'd0, 8'd1});

    // Asynchronous abort at beat 2 with green lit
    key = 1'b0;
    do_reset();
    start_game();
    hit_beat();
    hit_beat();
    key = 1'b1;
    tick(1);
    check("pre_abort", {27'd0, green, beat_idx, busy, 1'b0}, 32'b11010);
    #2 rst = 1'b0;
    #1;
    check("async_abort", 32'(obs), 32'd0);
    @(negedge clk);
    key = 1'b0;
    rst = 1'b1;
    tick(1);
    start_game();
    check("clean_restart", 32'(obs), {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
